// File: rtl/scalar_alu_arbiter_pkg.sv
// Shared codes for the scalar ALU arbiter and its ALU.
//  - alu_signal codes select the operand sources and the result width
//  - func_code codes select the arithmetic operation
//  - sign codes classify a result as positive, zero or negative
//  - arbiter state codes for the result-register FSM
package scalar_alu_arbiter_pkg;

  // alu_signal: operand routing / result width
  localparam logic [3:0] ALU_NOP        = 4'd0;  // no operation, result forced to zero
  localparam logic [3:0] BINARY         = 4'd1;  // rs1 op rs2, full width
  localparam logic [3:0] BINARY_WORD    = 4'd2;  // rs1 op rs2, low 32 bits sign-extended
  localparam logic [3:0] IMMEDIATE      = 4'd3;  // rs1 op imm, full width
  localparam logic [3:0] IMMEDIATE_WORD = 4'd4;  // rs1 op imm, low 32 bits sign-extended
  localparam logic [3:0] PC_REL         = 4'd5;  // zero-extended pc op imm, full width

  // func_code: operation
  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] ADDI = 4'd2;
  localparam logic [3:0] SLTI = 4'd3;  // signed set-less-than, result 0 or 1

  // sign_bits classification of a result
  localparam logic [1:0] ZERO = 2'd0;
  localparam logic [1:0] POS  = 2'd1;
  localparam logic [1:0] NEG  = 2'd2;

  localparam int WORD_LEN = 32;

  // Result register state: IDLE = empty, FULL = holds a result awaiting rsp_ready
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_FULL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/scalar_alu_arbiter_alu.sv
// Combinational scalar ALU shared by all requesters of the arbiter.
// Ports:
//  alu_signal  in   4               operand routing / width select
//  func_code   in   4               operation select
//  rs1, rs2    in   SCALAR_REG_LEN  register operands
//  imm         in   SCALAR_REG_LEN  immediate operand
//  pc          in   DATA_LEN        program counter (PC_REL only)
//  result      out  SCALAR_REG_LEN  operation result
//  sign_bits   out  2               POS / ZERO / NEG classification of result
module scalar_alu_arbiter_alu #(
  parameter int DATA_LEN       = 32,
  parameter int SCALAR_REG_LEN = 64
) (
  input  logic [3:0]                alu_signal,
  input  logic [3:0]                func_code,
  input  logic [SCALAR_REG_LEN-1:0] rs1,
  input  logic [SCALAR_REG_LEN-1:0] rs2,
  input  logic [SCALAR_REG_LEN-1:0] imm,
  input  logic [DATA_LEN-1:0]       pc,
  output logic [SCALAR_REG_LEN-1:0] result,
  output logic [1:0]                sign_bits
);
  import scalar_alu_arbiter_pkg::*;

  logic [SCALAR_REG_LEN-1:0] op_a;
  logic [SCALAR_REG_LEN-1:0] op_b;
  logic [SCALAR_REG_LEN-1:0] raw;

  always_comb begin
    op_a = rs1;
    op_b = imm;
    if (alu_signal == BINARY || alu_signal == BINARY_WORD) begin
      op_b = rs2;
    end
    if (alu_signal == PC_REL) begin
      op_a = {{(SCALAR_REG_LEN-DATA_LEN){1'b0}}, pc};
    end

    raw = '0;
    case (func_code)
      ADD, ADDI: raw = op_a + op_b;
      SUB:       raw = op_a - op_b;
      SLTI:      raw = {{(SCALAR_REG_LEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default:   raw = '0;
    endcase

    result = '0;
    case (alu_signal)
      BINARY, IMMEDIATE, PC_REL: result = raw;
      // Word ops keep the low 32 bits and sign-extend them to full width
      BINARY_WORD, IMMEDIATE_WORD:
        result = {{(SCALAR_REG_LEN-WORD_LEN){raw[WORD_LEN-1]}}, raw[WORD_LEN-1:0]};
      default: result = '0;
    endcase

    if (result == '0) begin
      sign_bits = ZERO;
    end else if (result[SCALAR_REG_LEN-1]) begin
      sign_bits = NEG;
    end else begin
      sign_bits = POS;
    end
  end

endmodule

// File: rtl/scalar_alu_arbiter.sv
// Round-robin arbiter sharing one scalar ALU between REQ_NUM requesters
// (slot 0: scalar issue path, slot 1: vector unit scalar-operand path).
// One op is accepted per cycle; its result is registered once and returned
// with the owning requester id over a valid/ready response channel.
// Ports:
//  clk, rst_n      clock (rising edge) and asynchronous active-low reset
//  req_valid       per-requester op valid
//  req_ready       per-requester accept, one-hot or zero
//  req_rs1/rs2/imm packed operands, slot i at [i*SCALAR_REG_LEN +: SCALAR_REG_LEN]
//  req_pc          packed pc, slot i at [i*DATA_LEN +: DATA_LEN]
//  req_alu_signal  packed 4-bit alu_signal per slot
//  req_func_code   packed 4-bit func_code per slot
//  rsp_valid       result register holds a result
//  rsp_ready       consumer takes the result this cycle
//  rsp_id          requester owning the result
//  rsp_result      registered ALU result
//  rsp_sign_bits   registered sign classification
module scalar_alu_arbiter #(
  parameter int REQ_NUM        = 2,
  parameter int REQ_IDX_SIZE   = 1,
  parameter int DATA_LEN       = 32,
  parameter int SCALAR_REG_LEN = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REQ_NUM-1:0]                req_valid,
  output logic [REQ_NUM-1:0]                req_ready,
  input  logic [REQ_NUM*SCALAR_REG_LEN-1:0] req_rs1,
  input  logic [REQ_NUM*SCALAR_REG_LEN-1:0] req_rs2,
  input  logic [REQ_NUM*SCALAR_REG_LEN-1:0] req_imm,
  input  logic [REQ_NUM*DATA_LEN-1:0]       req_pc,
  input  logic [REQ_NUM*4-1:0]              req_alu_signal,
  input  logic [REQ_NUM*4-1:0]              req_func_code,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [REQ_IDX_SIZE-1:0]           rsp_id,
  output logic [SCALAR_REG_LEN-1:0]         rsp_result,
  output logic [1:0]                        rsp_sign_bits
);
  import scalar_alu_arbiter_pkg::*;

  // First valid requester at or after ptr, wrapping; MSB of the return is "found".
  // The search runs from the farthest offset down so the nearest one wins.
  function automatic logic [REQ_IDX_SIZE:0] rr_pick(
    input logic [REQ_NUM-1:0]      valid,
    input logic [REQ_IDX_SIZE-1:0] ptr
  );
    logic [REQ_IDX_SIZE:0] pick;
    int cand;
    pick = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % REQ_NUM;
      if (valid[cand]) begin
        pick = {1'b1, cand[REQ_IDX_SIZE-1:0]};
      end
    end
    return pick;
  endfunction

  // Per-slot views of the packed request buses
  logic [SCALAR_REG_LEN-1:0] rs1_arr   [REQ_NUM];
  logic [SCALAR_REG_LEN-1:0] rs2_arr   [REQ_NUM];
  logic [SCALAR_REG_LEN-1:0] imm_arr   [REQ_NUM];
  logic [DATA_LEN-1:0]       pc_arr    [REQ_NUM];
  logic [3:0]                sig_arr   [REQ_NUM];
  logic [3:0]                func_arr  [REQ_NUM];

  arb_state_e                state_reg, state_next;
  logic [REQ_IDX_SIZE-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [REQ_IDX_SIZE-1:0]   rsp_id_reg;
  logic [SCALAR_REG_LEN-1:0] rsp_result_reg;
  logic [1:0]                rsp_sign_reg;

  logic [REQ_IDX_SIZE:0]     pick;
  logic                      grant_found;
  logic [REQ_IDX_SIZE-1:0]   grant_idx;
  logic                      can_accept;
  logic                      accept;

  logic [3:0]                alu_signal;
  logic [3:0]                alu_func;
  logic [SCALAR_REG_LEN-1:0] alu_rs1, alu_rs2, alu_imm;
  logic [DATA_LEN-1:0]       alu_pc;
  logic [SCALAR_REG_LEN-1:0] alu_result;
  logic [1:0]                alu_sign;

  assign pick        = rr_pick(req_valid, rr_ptr_reg);
  assign grant_found = pick[REQ_IDX_SIZE];
  assign grant_idx   = pick[REQ_IDX_SIZE-1:0];

  // rst_n gates acceptance so nothing is handed out while reset is held.
  // A full register can take a new op in the same cycle it is drained.
  assign can_accept = rst_n && ((state_reg == ARB_IDLE) || rsp_ready);
  assign accept     = grant_found && can_accept;

  genvar gi;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_slot
      assign rs1_arr[gi]   = req_rs1[gi*SCALAR_REG_LEN +: SCALAR_REG_LEN];
      assign rs2_arr[gi]   = req_rs2[gi*SCALAR_REG_LEN +: SCALAR_REG_LEN];
      assign imm_arr[gi]   = req_imm[gi*SCALAR_REG_LEN +: SCALAR_REG_LEN];
      assign pc_arr[gi]    = req_pc[gi*DATA_LEN +: DATA_LEN];
      assign sig_arr[gi]   = req_alu_signal[gi*4 +: 4];
      assign func_arr[gi]  = req_func_code[gi*4 +: 4];
      assign req_ready[gi] = accept && (grant_idx == REQ_IDX_SIZE'(gi));
    end
  endgenerate

  // Next-state, pointer update and ALU operand steering
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    alu_signal  = ALU_NOP;
    alu_func    = '0;
    alu_rs1     = '0;
    alu_rs2     = '0;
    alu_imm     = '0;
    alu_pc      = '0;

    if (accept) begin
      state_next  = ARB_FULL;
      rr_ptr_next = (grant_idx == REQ_IDX_SIZE'(REQ_NUM - 1)) ? '0
                                                              : grant_idx + REQ_IDX_SIZE'(1);
      alu_signal  = sig_arr[grant_idx];
      alu_func    = func_arr[grant_idx];
      alu_rs1     = rs1_arr[grant_idx];
      alu_rs2     = rs2_arr[grant_idx];
      alu_imm     = imm_arr[grant_idx];
      alu_pc      = pc_arr[grant_idx];
    end else if (state_reg == ARB_FULL && rsp_ready) begin
      state_next = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_IDLE;
      rr_ptr_reg     <= '0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_sign_reg   <= ZERO;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (accept) begin
        rsp_id_reg <= grant_idx;
        // A NOP request returns a clean zero regardless of the ALU output
        if (alu_signal == ALU_NOP) begin
          rsp_result_reg <= '0;
          rsp_sign_reg   <= ZERO;
        end else begin
          rsp_result_reg <= alu_result;
          rsp_sign_reg   <= alu_sign;
        end
      end
    end
  end

  assign rsp_valid     = (state_reg == ARB_FULL);
  assign rsp_id        = rsp_id_reg;
  assign rsp_result    = rsp_result_reg;
  assign rsp_sign_bits = rsp_sign_reg;

  scalar_alu_arbiter_alu #(
    .DATA_LEN      (DATA_LEN),
    .SCALAR_REG_LEN(SCALAR_REG_LEN)
  ) u_scalar_alu (
    .alu_signal(alu_signal),
    .func_code (alu_func),
    .rs1       (alu_rs1),
    .rs2       (alu_rs2),
    .imm       (alu_imm),
    .pc        (alu_pc),
    .result    (alu_result),
    .sign_bits (alu_sign)
  );

endmodule
